// File: rtl/traffic_disp_scan_if.sv
// Bundle between the traffic light controller and the display scanner.
// The master side drives timers and lights; the slave side drives the display outputs.
interface traffic_disp_scan_if;
  logic [6:0] TIMER0;
  logic [2:0] TF0;
  logic [6:0] TIMER1;
  logic [2:0] TF1;
  logic [6:0] SEG;
  logic [3:0] AN;
  logic [2:0] LED0;
  logic [2:0] LED1;
  logic       FRAME;

  modport master (
    output TIMER0, TF0, TIMER1, TF1,
    input  SEG, AN, LED0, LED1, FRAME
  );

  modport slave (
    input  TIMER0, TF0, TIMER1, TF1,
    output SEG, AN, LED0, LED1, FRAME
  );
endinterface

// File: rtl/traffic_disp_scan.sv
// 4-digit multiplexed 7-segment scanner for two countdown timers plus RYG LED groups.
// Define TRAFFIC_DISP_LZB_EN to blank a zero tens digit (leading-zero blanking).
module traffic_disp_scan #(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLANK_CYC = 1,
  parameter int unsigned PRESC_W   = 16
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  traffic_disp_scan_if.slave   bus
);

  typedef enum logic [1:0] {DIG0, DIG1, DIG2, DIG3} digit_e;

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);
  localparam logic [PRESC_W-1:0] BLANK_END  = PRESC_W'(BLANK_CYC);
  localparam logic [6:0]         SEG_BLANK  = 7'h7F;
  localparam logic [6:0]         SEG_DASH   = 7'h3F;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'h40;
      4'd1:    seg_code = 7'h79;
      4'd2:    seg_code = 7'h24;
      4'd3:    seg_code = 7'h30;
      4'd4:    seg_code = 7'h19;
      4'd5:    seg_code = 7'h12;
      4'd6:    seg_code = 7'h02;
      4'd7:    seg_code = 7'h78;
      4'd8:    seg_code = 7'h00;
      4'd9:    seg_code = 7'h10;
      default: seg_code = SEG_BLANK;
    endcase
  endfunction

  logic [PRESC_W-1:0] r_presc;
  digit_e             r_digit;
  logic [6:0]         r_snap_t0;
  logic [6:0]         r_snap_t1;
  logic [6:0]         r_seg;
  logic [3:0]         r_an;
  logic [2:0]         r_led0;
  logic [2:0]         r_led1;
  logic               r_frame;

  logic               w_slot_end;
  logic               w_snap;
  logic [6:0]         w_val;
  logic [3:0]         w_tens;
  logic [3:0]         w_ones;
  logic [6:0]         w_seg;
  logic [3:0]         w_an;

  assign w_slot_end = (r_presc == PRESC_LAST);
  assign w_snap     = w_slot_end && (r_digit == DIG3);

  // Digits 0/1 show TIMER0, digits 2/3 show TIMER1; odd digits are tens.
  assign w_val  = r_digit[1] ? r_snap_t1 : r_snap_t0;
  assign w_tens = 4'(w_val / 7'd10);
  assign w_ones = 4'(w_val % 7'd10);

  always_comb begin
    w_seg = SEG_BLANK;
    if (w_val > 7'd99) begin
      w_seg = SEG_DASH;
    end else if (r_digit[0]) begin
`ifdef TRAFFIC_DISP_LZB_EN
      w_seg = (w_tens == 4'd0) ? SEG_BLANK : seg_code(w_tens);
`else
      w_seg = seg_code(w_tens);
`endif
    end else begin
      w_seg = seg_code(w_ones);
    end
  end

  always_comb begin
    w_an = '1;
    if (r_presc >= BLANK_END) begin
      w_an = ~(4'b0001 << r_digit);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_presc   <= '0;
      r_digit   <= DIG0;
      r_snap_t0 <= '0;
      r_snap_t1 <= '0;
      r_seg     <= SEG_BLANK;
      r_an      <= '1;
      r_led0    <= '0;
      r_led1    <= '0;
      r_frame   <= 1'b0;
    end else begin
      r_presc <= w_slot_end ? '0 : r_presc + 1'b1;
      if (w_slot_end) begin
        r_digit <= digit_e'(r_digit + 2'd1);
      end
      // Snapshot lands together with the wrap to digit 0, so a whole frame sees one value set.
      r_frame <= w_snap;
      if (w_snap) begin
        r_snap_t0 <= bus.TIMER0;
        r_snap_t1 <= bus.TIMER1;
        r_led0    <= bus.TF0;
        r_led1    <= bus.TF1;
      end
      r_seg <= w_seg;
      r_an  <= w_an;
    end
  end

  assign bus.SEG   = r_seg;
  assign bus.AN    = r_an;
  assign bus.LED0  = r_led0;
  assign bus.LED1  = r_led1;
  assign bus.FRAME = r_frame;

endmodule

// File: tb/tb_traffic_disp_scan.sv
// Scoreboard bench for traffic_disp_scan: stimulus pushes expected frames at snapshot
// time; a monitor checks SEG/AN/FRAME/LED every cycle against arithmetic frame timing.
module tb_traffic_disp_scan;

  localparam int unsigned SDIV  = 4;
  localparam int unsigned FRAME_LEN = 4 * SDIV;
  localparam logic [6:0] GLYPH [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                        7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  typedef struct packed {
    logic [3:0][6:0] seg;
    logic [2:0]      led0;
    logic [2:0]      led1;
  } frame_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int unsigned cyc;
  int n_vec = 0;
  int n_bad = 0;
  frame_t exp_q[$];

  traffic_disp_scan_if bus();

  traffic_disp_scan #(
    .SCAN_DIV (SDIV),
    .BLANK_CYC(1),
    .PRESC_W  (16)
  ) dut (
    .CLK  (clk),
    .RST_N(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Cycles since reset release; outputs during cycle n reflect scan position n-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic frame_t make_frame(input int t0, input int t1,
                                        input logic [2:0] l0, input logic [2:0] l1);
    frame_t f;
    int v;
    f.led0 = l0;
    f.led1 = l1;
    for (int i = 0; i < 2; i++) begin
      v = (i == 0) ? t0 : t1;
      if (v > 99) begin
        f.seg[2*i]   = 7'h3F;
        f.seg[2*i+1] = 7'h3F;
      end else begin
        f.seg[2*i]   = GLYPH[v % 10];
        f.seg[2*i+1] = GLYPH[v / 10];
`ifdef TRAFFIC_DISP_LZB_EN
        if (v / 10 == 0) f.seg[2*i+1] = 7'h7F;
`endif
      end
    end
    return f;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d t=%0t: got %h expected %h", name, cyc, $time, act, exp);
    end
  endtask

  // Monitor: independent of stimulus, derives scan position from the cycle count.
  initial begin
    frame_t cur;
    int unsigned p, d;
    logic [3:0] ea;
    cur = make_frame(0, 0, 3'b000, 3'b000);
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cur = make_frame(0, 0, 3'b000, 3'b000);
      end else if (cyc > 0) begin
        p  = (cyc - 1) % FRAME_LEN;
        d  = p / SDIV;
        ea = ((p % SDIV) < 1) ? 4'hF : ~(4'b0001 << d);
        check("AN", bus.AN, ea);
        check("SEG", bus.SEG, cur.seg[d]);
        check("FRAME", bus.FRAME, (cyc % FRAME_LEN) == 0);
        if ((cyc % FRAME_LEN) == 0) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL QUEUE cyc=%0d: got empty scoreboard expected a frame", cyc);
          end else begin
            cur = exp_q.pop_front();
          end
        end
        check("LED0", bus.LED0, cur.led0);
        check("LED1", bus.LED1, cur.led1);
      end
    end
  end

  task automatic cycle_end();
    if (rst_n && (cyc % FRAME_LEN) == FRAME_LEN - 1)
      exp_q.push_back(make_frame(int'(bus.TIMER0), int'(bus.TIMER1), bus.TF0, bus.TF1));
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) cycle_end();
  endtask

  task automatic rand_run(input int n);
    repeat (n) begin
      if ($urandom_range(7) == 0) begin
        bus.TIMER0 = 7'($urandom_range(127));
        bus.TIMER1 = 7'($urandom_range(127));
        bus.TF0    = 3'($urandom);
        bus.TF1    = 3'($urandom);
      end
      cycle_end();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_SEG"},   bus.SEG,   7'h7F);
    check({tag, "_AN"},    bus.AN,    4'hF);
    check({tag, "_LED0"},  bus.LED0,  3'b000);
    check({tag, "_LED1"},  bus.LED1,  3'b000);
    check({tag, "_FRAME"}, bus.FRAME, 1'b0);
  endtask

  initial begin
    bus.TIMER0 = 7'd9;
    bus.TIMER1 = 7'd12;
    bus.TF0    = 3'b001;
    bus.TF1    = 3'b100;
    repeat (3) @(negedge clk);
    #1 check_reset_outputs("RST");
    #1 rst_n = 1'b1;

    // Mid-digit-1 change must wait for the next snapshot.
    run(22);
    bus.TIMER0 = 7'd8;
    run(42);
    bus.TIMER1 = 7'd100;
    run(FRAME_LEN);
    bus.TIMER1 = 7'd127;
    bus.TIMER0 = 7'd5;
    run(FRAME_LEN);
    bus.TIMER0 = 7'd0;
    bus.TIMER1 = 7'd99;
    run(FRAME_LEN);
    rand_run(320);

    // Reset mid-slot during digit 2.
    while ((cyc % FRAME_LEN) != 10) cycle_end();
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("MIDRST");
    exp_q.delete();
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    rand_run(96);
    run(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/traffic_disp_scan.md
Name: traffic_disp_scan

Overview:
- Display stage directly downstream of the traffic light controller.
- Consumes both countdown timers (TIMER0/TIMER1, 0..99) and both one-hot light vectors (TF0/TF1, R Y G).
- Drives a 4-digit multiplexed 7-segment display (two digits per direction) plus two registered RYG LED groups.
- Inputs are snapshotted once per frame, so a digit pair never shows a mix of old and new values.

Parameters:
- SCAN_DIV, 50000: CLK cycles per digit slot; legal range 2 or more.
- BLANK_CYC, 1: cycles at the start of each slot with all anodes off (anti-ghosting); legal range 0 to SCAN_DIV-1.
- PRESC_W, 16: prescaler width; must hold SCAN_DIV-1.

Ports:
- CLK  in  1  system clock
- RST_N  in  1  asynchronous, active-low reset
- TIMER0  in  7  direction-0 countdown value
- TF0  in  3  direction-0 lights {R,Y,G}
- TIMER1  in  7  direction-1 countdown value
- TF1  in  3  direction-1 lights {R,Y,G}
- SEG  out  7  segments {g,f,e,d,c,b,a}, active-low
- AN  out  4  digit enables, active-low; AN[0] is the rightmost digit
- LED0  out  3  registered TF0 snapshot
- LED1  out  3  registered TF1 snapshot
- FRAME  out  1  one-cycle pulse when a new snapshot is taken

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - prescaler=0, digit=0, snapshot registers=0
  - SEG=7'h7F, AN=4'b1111, LED0=LED1=3'b000, FRAME=0
- Prescaler: counts 0..SCAN_DIV-1 and wraps to 0. At wrap, digit advances 0→1→2→3→0.
- Digit mapping:
  - digit 0 = TIMER0 ones, digit 1 = TIMER0 tens
  - digit 2 = TIMER1 ones, digit 3 = TIMER1 tens
- Snapshot:
  - Taken on the cycle where prescaler=SCAN_DIV-1 and digit=3.
  - Captures TIMER0, TIMER1, TF0 and TF1 together.
  - FRAME is registered high on the following cycle, aligned with the first cycle of digit 0.
  - The first frame after reset displays the zeroed snapshot.
- BCD conversion:
  - tens = v/10, ones = v%10, computed combinationally from the snapshot.
  - Value >99 (100..127): both digits of that direction show a dash (7'h3F).
- Segment codes (active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex)
  - blank=7F, dash=3F
- Output timing:
  - SEG and AN are registered, one cycle behind the prescaler/digit state that selects them.
  - AN = all ones while prescaler < BLANK_CYC; otherwise only the bit for the current digit is low.
  - SEG keeps the current digit's code during blanking.
- LEDs:
  - LED0/LED1 are updated from the snapshot in the same cycle FRAME pulses.
  - Non-one-hot TF values pass through unchanged; this stage does not check them.
- Timer inputs changing mid-frame have no visible effect until the next snapshot.
- Reset mid-frame: outputs return to reset values immediately; scanning restarts at digit 0 with prescaler 0.

Optional Feature:
- Macro: TRAFFIC_DISP_LZB_EN
- When defined: a tens digit equal to 0 is blanked (7'h7F, AN bit still follows normal scanning). Dash handling is unchanged. A value of 0 shows a blank tens digit and "0" in the ones digit.
- When undefined: leading zeros are displayed ("07").

Test Plan (SCAN_DIV=4, BLANK_CYC=1, frame = 16 cycles):
- Release reset with TIMER0=9, TIMER1=12, TF0=001, TF1=100.
  - First frame shows all four digits as 40.
  - FRAME pulses at cycle 16 after release; LED0=001, LED1=100 then.
  - Second frame shows digit0=10, digit1=40, digit2=24, digit3=79.
- Per-slot anode check:
  - Slot cycle 0 (blank): AN=1111.
  - Slot cycles 1..3 for digit 2: AN=1011, with SEG/AN lagging the prescaler by one cycle.
- Change TIMER0 from 9 to 8 in the middle of digit 1.
  - Digit 0/1 output stays 10/40 until the next FRAME.
  - Output is 00/40 afterwards.
- TIMER1=100 and TIMER1=127: digits 2 and 3 show 3F; TIMER0 digits are unaffected.
- Assert RST_N low during digit 2, mid-slot.
  - Same cycle: AN=1111, SEG=7F, LEDs=000.
  - After release: digit 0 is the first enabled digit, and FRAME first pulses 16 cycles later.
- With TRAFFIC_DISP_LZB_EN defined and TIMER0=5: digit1=7F, digit0=12. With TIMER0=0: digit1=7F, digit0=40.
